// File: rtl/hps_register_bank_sccb_pkg.sv
// Shared definitions for the HPS register bank / SCCB command block:
// address map, dispatcher states and the queued command record.
package hps_reg_pkg;

    localparam logic [15:0] ADDR_STATUS    = 16'hFFF0;
    localparam logic [15:0] ADDR_CTRL      = 16'hFFF1;
    localparam logic [15:0] ADDR_CMD       = 16'hFFF2;
    localparam logic [31:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;

    // AW + DW is capped at 24 bits, so both fields fit the widest case
    localparam int CMD_FIELD_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        WAIT_ACK,
        WAIT_DONE
    } disp_state_t;

    typedef struct packed {
        logic [7:0]             mask;
        logic [CMD_FIELD_W-1:0] data;
        logic [CMD_FIELD_W-1:0] addr;
    } sccb_cmd_t;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hps_register_bank_sccb_fifo.sv
// Single-clock command queue with level output.
// Push while full is accepted only when a pop happens in the same cycle.
module sccb_cmd_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    if ((DEPTH < 2) || ((1 << PW) != DEPTH)) begin : g_bad_depth
        $error("FIFO depth must be a power of two and at least 2");
    end

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)
                r_level <= r_level + LW'(1);
            else if (w_do_pop && !w_do_push)
                r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/hps_register_bank_sccb.sv
// Avalon-MM register bank with frame-buffer registers and a queued
// command dispatcher that fans sensor writes out to NUM_CAM SCCB masters.
module hps_register_bank_sccb
    import hps_reg_pkg::*;
#(
    parameter int NUM_CAM      = 2,
    parameter int NUM_BUF_REGS = 4,
    parameter int SCCB_AW      = 16,
    parameter int SCCB_DW      = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [15:0]               avl_address,
    input  logic                      avl_chipselect,
    input  logic                      avl_write,
    input  logic                      avl_read,
    input  logic [31:0]               avl_writedata,
    output logic [31:0]               avl_readdata,
    output logic                      avl_readdatavalid,
    input  logic [NUM_CAM-1:0]        ready_cam,
    output logic [NUM_CAM-1:0]        start_cam,
    output logic [SCCB_AW-1:0]        sccb_addr,
    output logic [SCCB_DW-1:0]        sccb_data,
    output logic [NUM_BUF_REGS*32-1:0] reg_addr_buf,
    output logic                      start_write_image2ddr,
    output logic                      irq_err
);

    localparam int FW = NUM_CAM + SCCB_DW + SCCB_AW;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    if (SCCB_AW + SCCB_DW + 8 > 32) begin : g_bad_width
        $error("SCCB_AW + SCCB_DW + 8 must not exceed 32");
    end
    if (NUM_CAM < 1 || NUM_CAM > 8) begin : g_bad_cam
        $error("NUM_CAM must be in 1..8");
    end

    logic               w_wr;
    logic               w_rd;
    logic               w_ctrl_wr;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_clr;
    logic               w_empty;
    logic               w_full;
    logic               w_busy;
    logic [LW-1:0]      w_level;
    logic [NUM_CAM-1:0] w_cmd_mask;
    logic [FW-1:0]      w_fifo_din;
    logic [FW-1:0]      w_fifo_dout;
    logic [NUM_CAM-1:0] w_ovf_set;
    logic [NUM_CAM-1:0] w_tmo_set;
    logic [31:0]        w_status;
    logic [31:0]        w_rmux;
    logic [7:0]         w_ready8;
    logic [2:0]         w_low;
    logic [7:0]         w_mask_next;
    logic               w_ack_tmo;
    logic               w_unused;

    logic [31:0]        r_buf [NUM_BUF_REGS];
    logic [31:0]        r_rdata;
    logic               r_rvalid;
    logic               r_start_ddr;
    logic [NUM_CAM-1:0] r_ovf;
    logic [NUM_CAM-1:0] r_tmo;
    logic [NUM_CAM-1:0] r_start;
    disp_state_t        r_state;
    sccb_cmd_t          r_cmd;
    logic [2:0]         r_idx;
    logic [CW-1:0]      r_cnt;

    assign w_wr       = avl_chipselect & avl_write;
    assign w_rd       = avl_chipselect & avl_read;
    assign w_ctrl_wr  = w_wr && (avl_address == ADDR_CTRL);
    assign w_cmd_mask = avl_writedata[24 +: NUM_CAM];
    assign w_push     = w_wr && (avl_address == ADDR_CMD) && (|w_cmd_mask);
    assign w_flush    = w_ctrl_wr && avl_writedata[2] && (r_state == IDLE);
    assign w_clr      = w_ctrl_wr && avl_writedata[1];
    assign w_pop      = (r_state == IDLE) && !w_empty && !w_flush;
    assign w_ovf_set  = (w_push && w_full && !w_pop) ? w_cmd_mask : '0;
    assign w_fifo_din = {w_cmd_mask, avl_writedata[SCCB_AW+SCCB_DW-1:0]};
    assign w_busy     = (r_state != IDLE) || !w_empty;

    sccb_cmd_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (w_level)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUF_REGS; i++) r_buf[i] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NUM_BUF_REGS; i++) begin
                if (avl_address == 16'(i)) r_buf[i] <= avl_writedata;
            end
        end
    end

    for (genvar g = 0; g < NUM_BUF_REGS; g++) begin : g_flat
        assign reg_addr_buf[g*32 +: 32] = r_buf[g];
    end

    assign w_status = {8'(r_tmo), 8'(r_ovf), 8'(w_level), 7'd0, w_busy};

    always_comb begin
        w_rmux = RDATA_UNMAPPED;
        for (int i = 0; i < NUM_BUF_REGS; i++) begin
            if (avl_address == 16'(i)) w_rmux = r_buf[i];
        end
        if (avl_address == ADDR_STATUS) w_rmux = w_status;
        if (avl_address == ADDR_CTRL || avl_address == ADDR_CMD) w_rmux = '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_start_ddr <= 1'b0;
            r_ovf       <= '0;
            r_tmo       <= '0;
        end else begin
            r_rvalid    <= w_rd;
            if (w_rd) r_rdata <= w_rmux;
            r_start_ddr <= w_ctrl_wr && avl_writedata[0];
            // a fresh error in the clearing cycle survives the clear
            r_ovf <= (w_clr ? '0 : r_ovf) | w_ovf_set;
            r_tmo <= (w_clr ? '0 : r_tmo) | w_tmo_set;
        end
    end

    assign w_ready8    = 8'(ready_cam);
    assign w_low       = lowest_set(r_cmd.mask);
    assign w_mask_next = r_cmd.mask & ~(8'd1 << r_idx);
    assign w_ack_tmo   = (r_cnt == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        w_tmo_set = '0;
        for (int c = 0; c < NUM_CAM; c++) begin
            w_tmo_set[c] = (r_state == WAIT_ACK) && w_ready8[r_idx]
                        && w_ack_tmo && (3'(c) == r_idx);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_start <= '0;
        end else begin
            r_start <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cmd.mask <= 8'(w_fifo_dout[FW-1 -: NUM_CAM]);
                        r_cmd.data <= CMD_FIELD_W'(w_fifo_dout[SCCB_AW +: SCCB_DW]);
                        r_cmd.addr <= CMD_FIELD_W'(w_fifo_dout[SCCB_AW-1:0]);
                        r_state    <= SEL;
                    end
                end
                SEL: begin
                    if (w_ready8[w_low]) begin
                        for (int c = 0; c < NUM_CAM; c++) begin
                            r_start[c] <= (3'(c) == w_low);
                        end
                        r_idx   <= w_low;
                        r_cnt   <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!w_ready8[r_idx]) begin
                        r_state <= WAIT_DONE;
                    end else if (w_ack_tmo) begin
                        r_cmd.mask <= w_mask_next;
                        r_state    <= (w_mask_next == '0) ? IDLE : SEL;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (w_ready8[r_idx]) begin
                        r_cmd.mask <= w_mask_next;
                        r_state    <= (w_mask_next == '0) ? IDLE : SEL;
                    end
                end
            endcase
        end
    end

    assign w_unused = ^{r_cmd.addr, r_cmd.data};

    assign avl_readdata          = r_rdata;
    assign avl_readdatavalid     = r_rvalid;
    assign start_cam             = r_start;
    assign sccb_addr             = r_cmd.addr[SCCB_AW-1:0];
    assign sccb_data             = r_cmd.data[SCCB_DW-1:0];
    assign start_write_image2ddr = r_start_ddr;
    assign irq_err               = (|r_ovf) || (|r_tmo);

endmodule

// File: tb/tb_hps_register_bank_sccb.sv
// Bench for hps_register_bank_sccb: register vectors from a table,
// read and start-pulse scoreboards, and a simple SCCB master model.
module tb_hps_register_bank_sccb;

    localparam int NUM_CAM = 2;
    localparam int NUM_BUF = 4;
    localparam int FD      = 16;
    localparam int TMO     = 1023;

    logic                   clk_sys = 1'b0;
    logic                   reset_n = 1'b0;
    logic [15:0]            avl_address = '0;
    logic                   avl_chipselect = 1'b0;
    logic                   avl_write = 1'b0;
    logic                   avl_read = 1'b0;
    logic [31:0]            avl_writedata = '0;
    logic [31:0]            avl_readdata;
    logic                   avl_readdatavalid;
    logic [NUM_CAM-1:0]     ready_cam = '1;
    logic [NUM_CAM-1:0]     start_cam;
    logic [15:0]            sccb_addr;
    logic [7:0]             sccb_data;
    logic [NUM_BUF*32-1:0]  reg_addr_buf;
    logic                   start_write_image2ddr;
    logic                   irq_err;

    always #5 clk_sys = ~clk_sys;

    hps_register_bank_sccb #(
        .NUM_CAM      (NUM_CAM),
        .NUM_BUF_REGS (NUM_BUF),
        .SCCB_AW      (16),
        .SCCB_DW      (8),
        .FIFO_DEPTH   (FD),
        .ACK_TIMEOUT  (TMO)
    ) dut (
        .clk_sys               (clk_sys),
        .reset_n               (reset_n),
        .avl_address           (avl_address),
        .avl_chipselect        (avl_chipselect),
        .avl_write             (avl_write),
        .avl_read              (avl_read),
        .avl_writedata         (avl_writedata),
        .avl_readdata          (avl_readdata),
        .avl_readdatavalid     (avl_readdatavalid),
        .ready_cam             (ready_cam),
        .start_cam             (start_cam),
        .sccb_addr             (sccb_addr),
        .sccb_data             (sccb_data),
        .reg_addr_buf          (reg_addr_buf),
        .start_write_image2ddr (start_write_image2ddr),
        .irq_err               (irq_err)
    );

    typedef struct {
        logic [NUM_CAM-1:0] cam;
        logic [15:0]        addr;
        logic [7:0]         data;
    } start_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_t;

    typedef struct {
        int          op;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    start_t      sq[$];
    rd_t         rq[$];
    vec_t        tbl[16];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_starts = 0;
    int          last_start_cyc = 0;
    int          prev_start_cyc = 0;
    int          mode[NUM_CAM];
    int          busy[NUM_CAM];
    logic [15:0] hold_addr = '0;
    logic [7:0]  hold_data = '0;
    int          base;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    always @(posedge clk_sys) cyc++;

    // mode 0: normal master, 1: never leaves idle, 2: held busy
    always @(negedge clk_sys) begin
        start_t s;
        rd_t    r;
        if (!reset_n) begin
            for (int c = 0; c < NUM_CAM; c++) busy[c] = 0;
        end else begin
            if (start_cam != '0) begin
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
                n_starts++;
                if (sq.size() == 0) begin
                    check("start_unexpected", start_cam, 0);
                end else begin
                    s = sq.pop_front();
                    check("start_cam", start_cam, s.cam);
                    check("start_addr", sccb_addr, s.addr);
                    check("start_data", sccb_data, s.data);
                    hold_addr = s.addr;
                    hold_data = s.data;
                end
            end
            for (int c = 0; c < NUM_CAM; c++) begin
                if (busy[c] > 0) begin
                    check("sccb_addr_hold", sccb_addr, hold_addr);
                    check("sccb_data_hold", sccb_data, hold_data);
                    busy[c]--;
                end else if (start_cam[c] && mode[c] == 0) begin
                    busy[c] = 20;
                end
            end
            if (avl_readdatavalid) begin
                if (rq.size() == 0) begin
                    check("readvalid_unexpected", avl_readdatavalid, 0);
                end else begin
                    r = rq.pop_front();
                    check("readdata", avl_readdata, r.data);
                    check("read_latency", cyc, r.cyc);
                end
            end
        end
        for (int c = 0; c < NUM_CAM; c++) begin
            ready_cam[c] = (mode[c] == 2) ? 1'b0 :
                           (mode[c] == 1) ? 1'b1 : (busy[c] == 0);
        end
    end

    // op 0: write, 1: read, 2: write and read together
    task automatic bus(input int op, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        rd_t r;
        avl_chipselect = 1'b1;
        avl_address    = a;
        avl_writedata  = d;
        avl_write      = (op != 1);
        avl_read       = (op != 0);
        if (op != 0) begin
            r.data = exp;
            r.cyc  = cyc + 1;
            rq.push_back(r);
        end
        @(negedge clk_sys);
        avl_chipselect = 1'b0;
        avl_write      = 1'b0;
        avl_read       = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] m, input logic [7:0] d,
                       input logic [15:0] a, input bit accepted);
        start_t s;
        if (accepted) begin
            for (int c = 0; c < NUM_CAM; c++) begin
                if (m[c]) begin
                    s.cam  = NUM_CAM'(1 << c);
                    s.addr = a;
                    s.data = d;
                    sq.push_back(s);
                end
            end
        end
        bus(0, 16'hFFF2, {m, d, a}, 32'h0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k;
        k = 0;
        while (n_starts < target && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        check("start_count", n_starts, target);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cyc;
        tbl[0]  = '{0, 16'h0001, 32'h1234_5678, 32'h0};
        tbl[1]  = '{1, 16'h0001, 32'h0,         32'h1234_5678};
        tbl[2]  = '{0, 16'h0000, 32'hA5A5_0000, 32'h0};
        tbl[3]  = '{0, 16'h0003, 32'hFFFF_FFFF, 32'h0};
        tbl[4]  = '{0, 16'h0002, 32'h0000_0001, 32'h0};
        tbl[5]  = '{1, 16'h0000, 32'h0,         32'hA5A5_0000};
        tbl[6]  = '{1, 16'h0002, 32'h0,         32'h0000_0001};
        tbl[7]  = '{1, 16'h0003, 32'h0,         32'hFFFF_FFFF};
        tbl[8]  = '{1, 16'h0004, 32'h0,         32'hDEAD_BEEF};
        tbl[9]  = '{0, 16'h0100, 32'h0000_0001, 32'h0};
        tbl[10] = '{1, 16'h0100, 32'h0,         32'hDEAD_BEEF};
        tbl[11] = '{1, 16'hFFF1, 32'h0,         32'h0};
        tbl[12] = '{1, 16'hFFF0, 32'h0,         32'h0};
        tbl[13] = '{1, 16'hFFF3, 32'h0,         32'hDEAD_BEEF};
        tbl[14] = '{2, 16'h0002, 32'hCAFE_F00D, 32'h0000_0001};
        tbl[15] = '{1, 16'h0002, 32'h0,         32'hCAFE_F00D};

        idle(3);
        reset_n = 1'b1;
        idle(1);
        check("rst_start_cam", start_cam, 0);
        check("rst_rvalid", avl_readdatavalid, 0);
        check("rst_irq", irq_err, 0);
        check("rst_buf", reg_addr_buf, 0);
        check("rst_sccb_addr", sccb_addr, 0);
        check("rst_ddr", start_write_image2ddr, 0);

        for (int i = 0; i < 16; i++) bus(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].exp);
        check("buf1_flat", reg_addr_buf[63:32], 32'h1234_5678);
        check("buf_all", reg_addr_buf,
              {32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h1234_5678, 32'hA5A5_0000});

        bus(0, 16'hFFF1, 32'h1, 32'h0);
        check("ddr_pulse", start_write_image2ddr, 1);
        idle(1);
        check("ddr_pulse_end", start_write_image2ddr, 0);

        // single-camera command and issue latency
        wr_cyc = cyc;
        cmd(8'h01, 8'h42, 16'h3008, 1'b1);
        wait_starts(1, 50);
        check("issue_latency", last_start_cyc - wr_cyc, 3);
        bus(1, 16'hFFF0, 32'h0, 32'h0000_0001);
        idle(30);
        bus(1, 16'hFFF0, 32'h0, 32'h0);

        // broadcast, out-of-range mask bits, all-out-of-range mask
        cmd(8'h03, 8'h5A, 16'h1234, 1'b1);
        wait_starts(3, 200);
        idle(30);
        cmd(8'hFE, 8'h66, 16'h4321, 1'b1);
        wait_starts(4, 100);
        idle(30);
        cmd(8'h04, 8'h77, 16'h5555, 1'b0);
        idle(40);
        check("mask_dropped", n_starts, 4);
        bus(1, 16'hFFF0, 32'h0, 32'h0);

        // overflow: the dispatcher holds the first command, then FD fill
        mode[0] = 2;
        mode[1] = 2;
        idle(1);
        for (int i = 0; i <= FD; i++) cmd(8'h01, 8'(i), 16'h2000 + 16'(i), 1'b1);
        cmd(8'h01, 8'hEE, 16'h2FFF, 1'b0);
        bus(1, 16'hFFF0, 32'h0, 32'h0001_1001);
        idle(1);
        check("irq_after_ovf", irq_err, 1);
        bus(0, 16'hFFF1, 32'h4, 32'h0);
        bus(0, 16'hFFF1, 32'h2, 32'h0);
        check("irq_after_clr", irq_err, 0);
        bus(1, 16'hFFF0, 32'h0, 32'h0000_1001);
        mode[0] = 0;
        mode[1] = 0;
        wait_starts(4 + FD + 1, 1000);
        idle(30);
        bus(1, 16'hFFF0, 32'h0, 32'h0);

        // cam1 never acknowledges; next command must still go out
        mode[1] = 1;
        base = n_starts;
        cmd(8'h02, 8'h11, 16'h0A0A, 1'b1);
        cmd(8'h01, 8'h22, 16'h0B0B, 1'b1);
        wait_starts(base + 2, 1300);
        check("ack_timeout_gap", last_start_cyc - prev_start_cyc, TMO + 2);
        idle(30);
        bus(1, 16'hFFF0, 32'h0, 32'h0200_0000);
        idle(1);
        check("irq_after_tmo", irq_err, 1);
        bus(0, 16'hFFF1, 32'h2, 32'h0);
        check("irq_tmo_clr", irq_err, 0);
        mode[1] = 0;
        idle(2);

        // reset while a command is in WAIT_DONE
        base = n_starts;
        cmd(8'h01, 8'h77, 16'h3A3A, 1'b1);
        wait_starts(base + 1, 50);
        idle(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_sccb_addr", sccb_addr, 0);
        check("arst_sccb_data", sccb_data, 0);
        check("arst_buf", reg_addr_buf, 0);
        check("arst_rdata", avl_readdata, 0);
        check("arst_start", start_cam, 0);
        idle(2);
        reset_n = 1'b1;
        idle(40);
        check("no_start_after_rst", n_starts, base + 1);
        bus(1, 16'hFFF0, 32'h0, 32'h0);
        bus(1, 16'h0001, 32'h0, 32'h0);
        cmd(8'h01, 8'h99, 16'h6006, 1'b1);
        wait_starts(base + 2, 50);
        idle(30);

        check("rd_queue_empty", rq.size(), 0);
        check("start_queue_empty", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
